mlop_vec_scheduler: RTL
=======================

// Module: mlop_vec_scheduler
// PURPOSE
//  Time-shares one chunked vector MAC engine (weight/bias RAMs + WorkingRegs parallel MACs) between NumReq layer requesters.
//  Round-robin arbitration is done at whole-vector granularity.
//  Per granted vector, the block sequences chunk pops, weight/bias RAM addressing, output FIFO pushes and last/done flags.
//  Sits between per-requester input FIFOs (muxed externally by grant_out) and the shared output FIFO.
// PARAMETERS
//  NumReq      2   number of requesters sharing the engine (>=1)
//  InVecLength 16  elements per vector; multiple of WorkingRegs
//  WorkingRegs 4   elements per chunk; Chunks = InVecLength/WorkingRegs
//  RamLatency  1   cycles from chunk issue to MAC result valid (>=1)
// PORTS
//  clk_in        in   1                  single clock; all logic on posedge
//  rst_in        in   1                  asynchronous, active-high reset
//  req_in        in   NumReq             bit i: requester i has a full vector queued
//  grant_out     out  NumReq             one-hot owner of engine; 0 when idle
//  chunk_valid_in in  1                  granted input FIFO has a chunk at its head (FWFT)
//  chunk_pop_out out  1                  pop one chunk this cycle (issue)
//  wb_addr_out   out  $clog2(Chunks)|1   weight/bias RAM row for chunk issued this cycle
//  wb_bank_out   out  $clog2(NumReq)|1   weight/bias set select = index of granted requester
//  out_ready_in  in   1                  output FIFO has >= RamLatency+1 free slots
//  out_push_out  out  1                  write MAC result to output FIFO
//  out_last_out  out  1                  qualifies out_push_out: final chunk of vector
//  busy_out      out  1                  high from grant through final push
//  vec_done_out  out  1                  1-cycle pulse coincident with final push
// BEHAVIOUR
//  Reset (async, immediate, no clock needed):
//   - outputs: grant_out=0, wb_addr_out=0, wb_bank_out=0, all strobes=0, busy_out=0
//   - state=IDLE; issue pipeline flushed; RR pointer=0
//  FSM IDLE -> RUN -> DRAIN -> IDLE.
//  IDLE: if |req_in at the edge:
//   - grant the first set bit at or after RR pointer (circular search)
//   - register grant_out/wb_bank_out; wb_addr_out=0; busy_out=1; go RUN
//   - with no request, hold all outputs at reset values.
//  RUN: issue = chunk_valid_in & out_ready_in (combinational); chunk_pop_out = issue.
//   - wb_addr_out = index of the chunk popped that cycle; increments on issue only, holds otherwise.
//   - issue of chunk Chunks-1 -> DRAIN; wb_addr_out returns to 0.
//  Issue pipeline: shift register of depth RamLatency carrying {valid,last}.
//   - out_push_out = issue delayed exactly RamLatency cycles; out_last_out likewise.
//   - datapath aligns chunk data to RAM output; this block only times strobes.
//  DRAIN: no issues; wait for the last flag to emerge.
//   - on that cycle: out_push_out=1, out_last_out=1, vec_done_out=1.
//   - next edge: grant_out=0, busy_out=0, RR pointer=granted+1 mod NumReq, go IDLE.
//  Minimum one IDLE cycle between vectors (grant always drops for one cycle).
//  Boundary and edge-case rules:
//   - req_in changes while granted are ignored until IDLE; a dropped req does not abort the vector.
//   - out_ready_in low stalls issue only; in-flight pushes still complete (guaranteed by the slot contract).
//   - Chunks==1: first issue is also last; goes straight to DRAIN.
//   - Cycles per vector, no stalls: 1 (grant) + Chunks + RamLatency + 1 (idle).
//   - chunk_valid_in/out_ready_in are don't-care outside RUN; chunk_pop_out never asserts outside RUN.
//   - Reset mid-vector: abandon vector; no further push/done; the next grant restarts at wb_addr_out=0.
// TESTING
//  1 NumReq=2,Chunks=4,Lat=1; req_in=01, valid/ready=1 -> grant 01 @c1; pops c2-c5, addr 0,1,2,3; pushes c3-c6; last+done @c6; grant 00 @c7
//  2 req_in=11 held -> grants 01,10,01,10 alternating; each grant separated by >=1 cycle of grant=00
//  3 chunk_valid_in=0 for 2 cycles after the 2nd pop -> no pop, addr holds 2; pushes gap 2 cycles; done delayed 2 cycles
//  4 out_ready_in=0 for 3 cycles mid-vector -> issue stalls 3 cycles; the push already in flight still lands; total pushes=4, one last
//  5 rst_in pulsed between edges mid-RUN -> grant/strobes 0 immediately; after release, req_in=01 -> restart at addr 0, RR pointer 0
//  6 InVecLength=WorkingRegs=4,Lat=3 -> single pop; push+last+done 3 cycles later; busy_out high 5 cycles

Source files
------------

// File: rtl/mlop_vec_scheduler.sv
// Round-robin scheduler that time-shares one chunked vector MAC engine between
// NumReq requesters, sequencing chunk pops, weight/bias addressing and output pushes.
module mlop_vec_scheduler #(
   parameter  int NumReq      = 2,
   parameter  int InVecLength = 16,
   parameter  int WorkingRegs = 4,
   parameter  int RamLatency  = 1,
   localparam int Chunks      = InVecLength / WorkingRegs,
   localparam int AddrW       = (Chunks > 1) ? $clog2(Chunks) : 1,
   localparam int IdxW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [NumReq-1:0] req_in,
   output logic [NumReq-1:0] grant_out,
   input  logic              chunk_valid_in,
   output logic              chunk_pop_out,
   output logic [AddrW-1:0]  wb_addr_out,
   output logic [IdxW-1:0]   wb_bank_out,
   input  logic              out_ready_in,
   output logic              out_push_out,
   output logic              out_last_out,
   output logic              busy_out,
   output logic              vec_done_out
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [NumReq-1:0]     grant_q, grant_d;
   logic [IdxW-1:0]       bank_q, bank_d;
   logic [IdxW-1:0]       rr_q, rr_d;
   logic [AddrW-1:0]      addr_q, addr_d;
   logic                  busy_q, busy_d;
   logic                  setup_q, setup_d;
   logic [RamLatency-1:0] pv_q, pl_q;

   logic [IdxW-1:0]       sel_idx, hi_idx, lo_idx;
   logic                  hi_found;
   logic                  issue, issue_last, push, push_last;

   // Circular search: lowest set request at or above the pointer, else lowest overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (req_in[i]) begin
            lo_idx = IdxW'(i);
            if (IdxW'(i) >= rr_q) begin
               hi_idx   = IdxW'(i);
               hi_found = 1'b1;
            end
         end
      end
      sel_idx = hi_found ? hi_idx : lo_idx;
   end

   // The first RUN cycle issues nothing so the external FIFO mux can follow the new grant.
   assign issue      = (state_q == RUN) & ~setup_q & chunk_valid_in & out_ready_in;
   assign issue_last = (addr_q == AddrW'(Chunks - 1));
   assign push       = pv_q[RamLatency-1];
   assign push_last  = push & pl_q[RamLatency-1];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      bank_d  = bank_q;
      rr_d    = rr_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      setup_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_in) begin
               grant_d = NumReq'(1) << sel_idx;
               bank_d  = sel_idx;
               addr_d  = '0;
               busy_d  = 1'b1;
               setup_d = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (issue) begin
               if (issue_last) begin
                  addr_d  = '0;
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (push_last) begin
               grant_d = '0;
               bank_d  = '0;
               busy_d  = 1'b0;
               rr_d    = (bank_q == IdxW'(NumReq - 1)) ? '0 : bank_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         grant_q <= '0;
         bank_q  <= '0;
         rr_q    <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         setup_q <= 1'b0;
         pv_q    <= '0;
         pl_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         bank_q  <= bank_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         setup_q <= setup_d;
         pv_q[0] <= issue;
         pl_q[0] <= issue & issue_last;
         for (int k = 1; k < RamLatency; k++) begin
            pv_q[k] <= pv_q[k-1];
            pl_q[k] <= pl_q[k-1];
         end
      end
   end

   assign grant_out     = grant_q;
   assign wb_bank_out   = bank_q;
   assign wb_addr_out   = addr_q;
   assign busy_out      = busy_q;
   assign chunk_pop_out = issue;
   assign out_push_out  = push;
   assign out_last_out  = push_last;
   assign vec_done_out  = push_last;

endmodule
